pbch_descrambler: RTL and testbench
===================================

# pbch_descrambler

Downstream of the PBCH soft demapper: consumes the LLR stream (tdata/tuser/tlast/tvalid) and removes the PBCH scrambling sequence before the polar decoder. Generates the Gold sequence c(n) with c_init = N_id, advanced by Nc + v·N_BITS with v = ibar_SSB[1:0] (L_max = 4). For each c(n) = 1 it negates the corresponding LLR. Sits between the demapper and the PBCH LLR buffer / polar decoder.

## Interface
Parameters:
- LLR_DW, 8, LLR width (signed, two's complement)
- N_BITS, 864, LLRs per PBCH block (M_bit)
- NC, 1600, Gold sequence offset

Ports:
- clk_i  in  1  single clock
- reset_i  in  1  asynchronous, active-high reset
- N_id_i  in  10  cell ID (0..1007), sampled on N_id_valid_i
- N_id_valid_i  in  1  one-cycle strobe that starts sequence initialisation
- ibar_SSB_i  in  3  SSB index, sampled with N_id_i; only bits [1:0] used
- s_axis_llr_tdata  in  LLR_DW  input LLR
- s_axis_llr_tuser  in  2  passed through unchanged
- s_axis_llr_tlast  in  1  last LLR of block
- s_axis_llr_tvalid  in  1  input valid; there is no tready
- m_axis_llr_tdata  out  LLR_DW  descrambled LLR
- m_axis_llr_tuser  out  2  delayed tuser
- m_axis_llr_tlast  out  1  delayed tlast, or forced on the N_BITS-th LLR
- m_axis_llr_tvalid  out  1  output valid
- ready_o  out  1  high in RUN
- done_o  out  1  one-cycle pulse when a block ends
- overflow_o  out  1  sticky; cleared by N_id_valid_i

## Operation
- Registers:
  - x1: 31-bit LFSR, init 1; feedback x1[3]^x1[0].
  - x2: 31-bit LFSR, init {21'b0, N_id}; feedback x2[3]^x2[2]^x2[1]^x2[0].
  - Shifting right, with feedback into bit 30.
  - c = x1[0]^x2[0].
- State machine:
  - IDLE → WARMUP on N_id_valid_i. Load the LFSRs and set warm_cnt = NC + ibar_SSB_i[1:0]·N_BITS (13 bits, max 4192).
  - WARMUP: shift both LFSRs once per cycle and decrement warm_cnt. When warm_cnt = 0 (counter reached zero, no shift that cycle), go to RUN and set bit_cnt = 0.
  - RUN: for each s_axis_llr_tvalid:
    - Output the LLR, negated if c = 1.
    - Shift the LFSRs and increment bit_cnt.
    - If s_axis_llr_tlast or bit_cnt = N_BITS-1: assert m tlast, pulse done_o, go to IDLE.
- Negation: see Configuration. The c = 0 path passes the value bit-exact.
- Boundary conditions:
  - tvalid in IDLE or WARMUP: the LLR is dropped, no output, overflow_o ← 1.
  - N_id_valid_i in any state, including mid-RUN: abort the current block (no done_o, no forced tlast), reload, enter WARMUP, clear overflow_o. If it coincides with an input tvalid, the input is dropped and overflow_o is not set.
  - tlast before N_BITS LLRs: the block ends early, done_o pulses, and the next block requires a new N_id_valid_i.
  - No tvalid gaps constraint: the LFSR advances only on accepted LLRs.

## Timing
- Reset values: all outputs 0, state IDLE, LFSRs 0, counters 0.
- Initialisation: N_id_valid_i at cycle t gives ready_o = 1 at cycle t+1+NC+v·N_BITS.
  - Example: v = 0 → t+1601.
- Latency: 1 cycle from s_axis_llr_tvalid to m_axis_llr_tvalid. tuser and tlast are aligned to the same cycle.
- Throughput: one LLR per cycle, back-to-back.
- done_o coincides with the last m_axis_llr_tvalid. ready_o falls in that same cycle.

## Configuration
- Macro `PBCH_DESCR_SAT_EN`.
  - Defined: negation saturates, so −2^(LLR_DW−1) becomes 2^(LLR_DW−1)−1 (−128 → +127 for LLR_DW = 8).
  - Undefined: plain two's-complement negate, so −128 stays −128. All other values are identical in both builds.

## Test plan
- N_id = 0, ibar = 0, 864 LLRs of +10 → output signs match the golden model c(1600..2463), ready_o at t+1601, one done_o with tlast on output #864.
- N_id = 1007, ibar = 3'b111 (v = 3), LLRs ramp −100..+100 → ready_o at t+4193; magnitudes unchanged, signs match c(4192..5055).
- LLR −128 at a position where c = 1 → +127 with `PBCH_DESCR_SAT_EN`, −128 without; LLR +127 at c = 1 → −127 in both builds.
- 5 LLRs during WARMUP → no output, overflow_o = 1. New N_id_valid_i → overflow_o = 0.
- Block 1 interrupted after 300 LLRs by N_id_valid_i → no done_o. Block 2 restarts at c(1600), and a tlast at LLR #500 → done_o pulse, then IDLE.
- Reset asserted mid-RUN → all outputs 0 asynchronously. After release, LLRs are dropped until a new init.

Source files
------------

// File: rtl/pbch_descrambler_if.sv
// LLR stream bundle between demapper, descrambler and PBCH LLR buffer.
// Valid-only stream: there is no back-pressure path, the sink must accept every beat.
interface pbch_descrambler_if #(
  parameter int LLR_DW = 8
);
  logic [LLR_DW-1:0] tdata;
  logic [1:0]        tuser;
  logic              tlast;
  logic              tvalid;

  modport master (output tdata, tuser, tlast, tvalid);
  modport slave  (input  tdata, tuser, tlast, tvalid);
endinterface

// File: rtl/pbch_descrambler.sv
// PBCH descrambler: negates each LLR where the Gold sequence bit is 1; 1-cycle latency, no back-pressure.
// Beats outside RUN are dropped and flagged on overflow_o. `PBCH_DESCR_SAT_EN selects saturating negation.
module pbch_descrambler #(
  parameter int LLR_DW = 8,
  parameter int N_BITS = 864,
  parameter int NC     = 1600
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [9:0]         N_id_i,
  input  logic               N_id_valid_i,
  input  logic [2:0]         ibar_SSB_i,
  pbch_descrambler_if.slave  s_axis_llr,
  pbch_descrambler_if.master m_axis_llr,
  output logic               ready_o,
  output logic               done_o,
  output logic               overflow_o
);
  localparam int              CW       = $clog2(N_BITS);
  localparam logic [12:0]     NC_W     = 13'(NC);
  localparam logic [12:0]     NB_W     = 13'(N_BITS);
  localparam logic [CW-1:0]   LAST_IDX = CW'(N_BITS - 1);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

  state_t            r_state;
  logic [30:0]       r_x1;
  logic [30:0]       r_x2;
  logic [12:0]       r_warm_cnt;
  logic [CW-1:0]     r_bit_cnt;
  logic [LLR_DW-1:0] r_m_tdata;
  logic [1:0]        r_m_tuser;
  logic              r_m_tlast;
  logic              r_m_tvalid;
  logic              r_ready;
  logic              r_done;
  logic              r_overflow;

  logic              w_c;
  logic [30:0]       w_x1_nxt;
  logic [30:0]       w_x2_nxt;
  logic [12:0]       w_warm_init;
  logic [LLR_DW-1:0] w_neg;
  logic              w_end;
  logic              w_unused;

  assign w_c         = r_x1[0] ^ r_x2[0];
  assign w_x1_nxt    = {r_x1[3] ^ r_x1[0], r_x1[30:1]};
  assign w_x2_nxt    = {r_x2[3] ^ r_x2[2] ^ r_x2[1] ^ r_x2[0], r_x2[30:1]};
  assign w_warm_init = NC_W + 13'(ibar_SSB_i[1:0]) * NB_W;
  assign w_end       = s_axis_llr.tlast || (r_bit_cnt == LAST_IDX);
  // Only L_max = 4 is supported, so the top SSB index bit carries no information here.
  assign w_unused    = ibar_SSB_i[2];

`ifdef PBCH_DESCR_SAT_EN
  localparam logic [LLR_DW-1:0] MIN_LLR = {1'b1, {(LLR_DW-1){1'b0}}};
  assign w_neg = (s_axis_llr.tdata == MIN_LLR) ? ~MIN_LLR : -s_axis_llr.tdata;
`else
  assign w_neg = -s_axis_llr.tdata;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_x1       <= '0;
      r_x2       <= '0;
      r_warm_cnt <= '0;
      r_bit_cnt  <= '0;
      r_m_tdata  <= '0;
      r_m_tuser  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tvalid <= 1'b0;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_done     <= 1'b0;
      if (N_id_valid_i) begin
        // Re-initialisation wins over everything, including a coincident input beat.
        r_x1       <= 31'd1;
        r_x2       <= {21'b0, N_id_i};
        r_warm_cnt <= w_warm_init;
        r_bit_cnt  <= '0;
        r_ready    <= 1'b0;
        r_overflow <= 1'b0;
        r_state    <= WARMUP;
      end else begin
        case (r_state)
          IDLE: begin
            if (s_axis_llr.tvalid) r_overflow <= 1'b1;
          end
          WARMUP: begin
            if (s_axis_llr.tvalid) r_overflow <= 1'b1;
            if (r_warm_cnt == 13'd0) begin
              r_state   <= RUN;
              r_ready   <= 1'b1;
              r_bit_cnt <= '0;
            end else begin
              r_x1       <= w_x1_nxt;
              r_x2       <= w_x2_nxt;
              r_warm_cnt <= r_warm_cnt - 13'd1;
            end
          end
          RUN: begin
            if (s_axis_llr.tvalid) begin
              r_m_tvalid <= 1'b1;
              r_m_tdata  <= w_c ? w_neg : s_axis_llr.tdata;
              r_m_tuser  <= s_axis_llr.tuser;
              r_x1       <= w_x1_nxt;
              r_x2       <= w_x2_nxt;
              r_bit_cnt  <= r_bit_cnt + CW'(1);
              if (w_end) begin
                r_m_tlast <= 1'b1;
                r_done    <= 1'b1;
                r_ready   <= 1'b0;
                r_state   <= IDLE;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign m_axis_llr.tdata  = r_m_tdata;
  assign m_axis_llr.tuser  = r_m_tuser;
  assign m_axis_llr.tlast  = r_m_tlast;
  assign m_axis_llr.tvalid = r_m_tvalid;
  assign ready_o           = r_ready;
  assign done_o            = r_done;
  assign overflow_o        = r_overflow;
endmodule

// File: tb/tb_pbch_descrambler.sv
// Bench for pbch_descrambler: Gold sequence reference built from the LFSR recurrences over plain bit arrays.
`timescale 1ns/1ps
module tb_pbch_descrambler;
  localparam int LLR_DW = 8;
  localparam int N_BITS = 864;
  localparam int NC     = 1600;
  localparam int GMAX   = NC + 4 * N_BITS + 8;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [9:0] N_id_i;
  logic       N_id_valid_i;
  logic [2:0] ibar_SSB_i;
  logic       ready_o, done_o, overflow_o;

  pbch_descrambler_if #(.LLR_DW(LLR_DW)) s_if ();
  pbch_descrambler_if #(.LLR_DW(LLR_DW)) m_if ();

  pbch_descrambler #(.LLR_DW(LLR_DW), .N_BITS(N_BITS), .NC(NC)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .N_id_i       (N_id_i),
    .N_id_valid_i (N_id_valid_i),
    .ibar_SSB_i   (ibar_SSB_i),
    .s_axis_llr   (s_if),
    .m_axis_llr   (m_if),
    .ready_o      (ready_o),
    .done_o       (done_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_total = 0;

  bit gx1 [0:GMAX+30];
  bit gx2 [0:GMAX+30];
  bit g   [0:GMAX-1];
  int pos;
  int blk_cnt;

  typedef struct {
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // g[m] = x1(m) ^ x2(m), with x1/x2 defined by their 31-step recurrences.
  task automatic gold(input int nid);
    for (int i = 0; i < 31; i++) begin
      gx1[i] = (i == 0);
      gx2[i] = (i < 10) ? nid[i] : 1'b0;
    end
    for (int n = 0; n < GMAX; n++) begin
      gx1[n+31] = gx1[n+3] ^ gx1[n];
      gx2[n+31] = gx2[n+3] ^ gx2[n+2] ^ gx2[n+1] ^ gx2[n];
    end
    for (int m = 0; m < GMAX; m++) g[m] = gx1[m] ^ gx2[m];
  endtask

  function automatic logic [7:0] neg_model(input logic [7:0] d);
    int v;
    v = -int'($signed(d));
`ifdef PBCH_DESCR_SAT_EN
    if (v > 127) v = 127;
`endif
    return v[7:0];
  endfunction

  task automatic init(input int nid, input logic [2:0] ib, input int warm_llr, input bit tv_too);
    int k;
    int exp_lat;
    N_id_i       = nid[9:0];
    ibar_SSB_i   = ib;
    N_id_valid_i = 1'b1;
    s_if.tvalid  = tv_too;
    s_if.tdata   = 8'h11;
    tick();
    N_id_valid_i = 1'b0;
    s_if.tvalid  = 1'b0;
    chk("init_no_out", m_if.tvalid, 0);
    chk("init_no_done", done_o, 0);
    chk("init_ovf_clear", overflow_o, 0);
    exp_lat = 1 + NC + int'(ib[1:0]) * N_BITS;
    k = 0;
    while (!ready_o && k < 6000) begin
      s_if.tvalid = (k < warm_llr);
      tick();
      k++;
      if (k <= warm_llr) chk("warm_drop", m_if.tvalid, 0);
    end
    s_if.tvalid = 1'b0;
    chk("ready_latency", k, exp_lat);
    chk("ovf_after_warm", overflow_o, (warm_llr > 0) ? 1 : 0);
    gold(nid);
    pos     = NC + int'(ib[1:0]) * N_BITS;
    blk_cnt = 0;
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] u, input bit last, output logic [7:0] got);
    bit         endb;
    logic [7:0] e;
    endb = last || (blk_cnt == N_BITS - 1);
    e    = g[pos] ? neg_model(d) : d;
    s_if.tdata  = d;
    s_if.tuser  = u;
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
    tick();
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    got = m_if.tdata;
    chk($sformatf("out_vld[%0d]", pos), m_if.tvalid, 1);
    chk($sformatf("out_dat[%0d]", pos), m_if.tdata, e);
    chk($sformatf("out_usr[%0d]", pos), m_if.tuser, u);
    chk($sformatf("out_last[%0d]", pos), m_if.tlast, endb);
    chk($sformatf("done[%0d]", pos), done_o, endb);
    if (endb) chk("ready_fall", ready_o, 0);
    pos++;
    blk_cnt++;
  endtask

  task automatic gap();
    s_if.tvalid = 1'b0;
    tick();
    chk("gap_no_out", m_if.tvalid, 0);
    chk("gap_no_done", done_o, 0);
  endtask

  task automatic idle_drop();
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'h33;
    tick();
    s_if.tvalid = 1'b0;
    chk("idle_no_out", m_if.tvalid, 0);
    chk("idle_ready_low", ready_o, 0);
    chk("idle_ovf_set", overflow_o, 1);
  endtask

  initial begin
    vec_t       tbl [7];
    logic [7:0] got;
    int         len, guard;
    logic [2:0] ib;

    tbl[0] = '{8'h7F, 8'h81};   // +127 -> -127
`ifdef PBCH_DESCR_SAT_EN
    tbl[1] = '{8'h80, 8'h7F};   // -128 -> +127
`else
    tbl[1] = '{8'h80, 8'h80};   // -128 stays -128
`endif
    tbl[2] = '{8'h00, 8'h00};
    tbl[3] = '{8'h01, 8'hFF};
    tbl[4] = '{8'hFF, 8'h01};
    tbl[5] = '{8'h0A, 8'hF6};
    tbl[6] = '{8'h9C, 8'h64};   // -100 -> +100

    reset_i      = 1'b1;
    N_id_i       = '0;
    N_id_valid_i = 1'b0;
    ibar_SSB_i   = '0;
    s_if.tdata   = '0;
    s_if.tuser   = '0;
    s_if.tlast   = 1'b0;
    s_if.tvalid  = 1'b0;
    #3;
    chk("rst_tvalid", m_if.tvalid, 0);
    chk("rst_tdata", m_if.tdata, 0);
    chk("rst_tuser", m_if.tuser, 0);
    chk("rst_tlast", m_if.tlast, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ovf", overflow_o, 0);
    tick();
    tick();
    reset_i = 1'b0;
    tick();

    // Full block, constant +10, forced tlast on the 864th LLR.
    init(0, 3'd0, 0, 1'b0);
    for (int i = 0; i < N_BITS; i++) push(8'd10, 2'(i % 4), 1'b0, got);
    gap();
    chk("a_ready_idle", ready_o, 0);

    // v = 3 via ibar = 3'b111, ramp -100..+100.
    init(1007, 3'b111, 0, 1'b0);
    for (int i = 0; i < N_BITS; i++) push(8'(-100 + (i % 201)), 2'(i % 4), 1'b0, got);
    gap();

    // Edge vectors, each placed at the next position where c = 1.
    init(37, 3'd0, 0, 1'b0);
    for (int t = 0; t < 7; t++) begin
      guard = 0;
      while (!g[pos] && guard < 64) begin
        push(8'd5, 2'd1, 1'b0, got);
        guard++;
      end
      push(tbl[t].d, 2'd2, (t == 6), got);
      chk($sformatf("vec%0d", t), got, tbl[t].exp);
    end
    idle_drop();

    // LLRs during warm-up, then re-init with a coincident (dropped) beat.
    init(500, 3'd1, 5, 1'b0);
    init(500, 3'd0, 0, 1'b1);
    for (int i = 0; i < 300; i++) push(8'($urandom), 2'($urandom), 1'b0, got);
    // Abort mid-block and restart; the new block begins again at c(1600).
    init(0, 3'd0, 0, 1'b0);
    chk("restart_pos", pos, NC);
    for (int i = 0; i < 500; i++) push(8'($urandom), 2'($urandom), (i == 499), got);
    idle_drop();

    // Random blocks with gaps and random length.
    for (int r = 0; r < 4; r++) begin
      ib  = 3'($urandom_range(0, 7));
      init(int'($urandom_range(0, 1007)), ib, 0, 1'b0);
      len = (r == 0) ? N_BITS : int'($urandom_range(1, N_BITS - 1));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) gap();
        push(8'($urandom), 2'($urandom), (len < N_BITS) && (i == len - 1), got);
      end
      idle_drop();
    end

    // Asynchronous reset in the middle of a block.
    init(123, 3'd0, 0, 1'b0);
    for (int i = 0; i < 20; i++) push(8'($urandom_range(1, 127)), 2'd3, 1'b0, got);
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'h44;
    reset_i     = 1'b1;
    #1;
    chk("arst_tvalid", m_if.tvalid, 0);
    chk("arst_tdata", m_if.tdata, 0);
    chk("arst_tuser", m_if.tuser, 0);
    chk("arst_tlast", m_if.tlast, 0);
    chk("arst_ready", ready_o, 0);
    chk("arst_done", done_o, 0);
    chk("arst_ovf", overflow_o, 0);
    tick();
    tick();
    reset_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_if.tvalid = 1'b1;
      tick();
      chk("post_rst_drop", m_if.tvalid, 0);
      chk("post_rst_ready", ready_o, 0);
    end
    s_if.tvalid = 1'b0;
    chk("post_rst_ovf", overflow_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end
endmodule
